fft_peak_finder: RTL and testbench

//  Downstream consumer of the 32-point FFT output stream (natural-order bins, 16-bit signed re/im).

---
 rtl/fft_pkg.sv | 17 +
 rtl/cplx_mag2.sv | 48 ++++
 rtl/fft_peak_finder.sv | 216 +++++++++++++++++++++
 tb/tb_fft_peak_finder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and FSM state type for the FFT post-processing blocks.
package fft_pkg;

    localparam int unsigned N_PT  = 32;
    localparam int unsigned DW    = 16;
    localparam int unsigned LOG2N = $clog2(N_PT);
    localparam int unsigned POW_W = 2 * DW;
    localparam int unsigned ENG_W = POW_W + LOG2N;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        DONE
    } state_e;

endpackage

// File: rtl/cplx_mag2.sv
// Registered squared magnitude re^2 + im^2 of a signed complex sample, 1-cycle latency.
module cplx_mag2 #(
    parameter int unsigned DW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_clr,
    input  logic                 i_valid,
    input  logic signed [DW-1:0] i_re,
    input  logic signed [DW-1:0] i_im,
    output logic                 o_valid,
    output logic [2*DW-1:0]      o_mag2
);

    logic signed [2*DW-1:0] w_re_ext;
    logic signed [2*DW-1:0] w_im_ext;
    logic signed [2*DW-1:0] w_re2;
    logic signed [2*DW-1:0] w_im2;
    logic        [2*DW-1:0] w_sum;

    logic                   r_valid;
    logic        [2*DW-1:0] r_mag2;

    assign w_re_ext = {{DW{i_re[DW-1]}}, i_re};
    assign w_im_ext = {{DW{i_im[DW-1]}}, i_im};
    assign w_re2    = w_re_ext * w_re_ext;
    assign w_im2    = w_im_ext * w_im_ext;
    // Each square is at most 2^(2DW-2), so the unsigned sum cannot overflow 2*DW bits.
    assign w_sum    = $unsigned(w_re2) + $unsigned(w_im2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_mag2  <= '0;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_mag2 <= w_sum;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_mag2  = r_mag2;

endmodule

// File: rtl/fft_peak_finder.sv
// Per-frame power peak search and energy accumulation over a natural-order FFT bin stream.
module fft_peak_finder #(
    parameter int unsigned N_PT    = fft_pkg::N_PT,
    parameter int unsigned DW      = fft_pkg::DW,
    parameter bit          SKIP_DC = 1'b0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clr,
    input  logic                            in_valid,
    input  logic signed [DW-1:0]            din_r,
    input  logic signed [DW-1:0]            din_i,
    output logic                            busy,
    output logic                            peak_valid,
    output logic [$clog2(N_PT)-1:0]         peak_bin,
    output logic [2*DW-1:0]                 peak_pow,
    output logic [2*DW+$clog2(N_PT)-1:0]    energy
);

    import fft_pkg::*;

    localparam int unsigned BIN_W = $clog2(N_PT);
    localparam int unsigned P_W   = 2 * DW;
    localparam int unsigned E_W   = P_W + BIN_W;

    localparam logic [BIN_W-1:0] LAST_BIN  = BIN_W'(N_PT - 1);
    localparam logic [BIN_W-1:0] FIRST_BIN = SKIP_DC ? BIN_W'(1) : '0;
    localparam logic [1:0]       DRAIN_END = 2'd2;

    state_e             r_state;
    state_e             w_state_d;
    logic [BIN_W-1:0]   r_cnt;
    logic [BIN_W-1:0]   w_cnt_d;
    logic [BIN_W-1:0]   w_bin;
    logic [1:0]         r_drain;
    logic [1:0]         w_drain_d;
    logic               w_take;
    logic               w_strobe;

    logic               r_s1_vld;
    logic signed [DW-1:0] r_s1_re;
    logic signed [DW-1:0] r_s1_im;
    logic [BIN_W-1:0]   r_s1_bin;

    logic               w_s2_vld;
    logic [P_W-1:0]     w_s2_pow;
    logic [BIN_W-1:0]   r_s2_bin;

    logic [E_W-1:0]     r_acc_eng;
    logic [P_W-1:0]     r_max_pow;
    logic [BIN_W-1:0]   r_max_bin;
    logic               w_searched;
    logic               w_better;

    logic               r_peak_valid;
    logic [BIN_W-1:0]   r_peak_bin;
    logic [P_W-1:0]     r_peak_pow;
    logic [E_W-1:0]     r_energy;

    // Frame-level control.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_drain <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_drain <= w_drain_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_drain_d = r_drain;
        w_take    = 1'b0;
        w_strobe  = 1'b0;
        w_bin     = r_cnt;
        if (clr) begin
            w_state_d = IDLE;
            w_cnt_d   = '0;
            w_drain_d = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_bin = '0;
                    if (in_valid) begin
                        w_take    = 1'b1;
                        w_cnt_d   = BIN_W'(1);
                        w_state_d = ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        w_take = 1'b1;
                        if (r_cnt == LAST_BIN) begin
                            w_cnt_d   = '0;
                            w_drain_d = '0;
                            w_state_d = DRAIN;
                        end else begin
                            w_cnt_d = r_cnt + BIN_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    // Last bin reaches S3 two edges after sampling; results load on the third.
                    if (r_drain == DRAIN_END) begin
                        w_strobe  = 1'b1;
                        w_drain_d = '0;
                        w_state_d = DONE;
                    end else begin
                        w_drain_d = r_drain + 2'd1;
                    end
                end
                DONE: begin
                    if (!in_valid) begin
                        w_state_d = IDLE;
                    end
                end
                default: w_state_d = IDLE;
            endcase
        end
    end

    // S1: input capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_s1_re  <= '0;
            r_s1_im  <= '0;
            r_s1_bin <= '0;
        end else if (clr) begin
            r_s1_vld <= 1'b0;
        end else begin
            r_s1_vld <= w_take;
            if (w_take) begin
                r_s1_re  <= din_r;
                r_s1_im  <= din_i;
                r_s1_bin <= w_bin;
            end
        end
    end

    // S2: squared magnitude.
    cplx_mag2 #(
        .DW (DW)
    ) u_mag2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (clr),
        .i_valid (r_s1_vld),
        .i_re    (r_s1_re),
        .i_im    (r_s1_im),
        .o_valid (w_s2_vld),
        .o_mag2  (w_s2_pow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_bin <= '0;
        end else if (!clr && r_s1_vld) begin
            r_s2_bin <= r_s1_bin;
        end
    end

    // S3: energy accumulation and running max; bin 0 restarts the sum.
    assign w_searched = !(SKIP_DC && (r_s2_bin == '0));
    assign w_better   = (r_s2_bin == FIRST_BIN) || (w_s2_pow > r_max_pow);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_eng <= '0;
            r_max_pow <= '0;
            r_max_bin <= '0;
        end else if (clr) begin
            r_acc_eng <= '0;
            r_max_pow <= '0;
            r_max_bin <= '0;
        end else if (w_s2_vld) begin
            if (r_s2_bin == '0) begin
                r_acc_eng <= E_W'(w_s2_pow);
            end else begin
                r_acc_eng <= r_acc_eng + E_W'(w_s2_pow);
            end
            if (w_searched && w_better) begin
                r_max_pow <= w_s2_pow;
                r_max_bin <= r_s2_bin;
            end
        end
    end

    // Result registers hold the last completed frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_peak_valid <= 1'b0;
            r_peak_bin   <= '0;
            r_peak_pow   <= '0;
            r_energy     <= '0;
        end else begin
            r_peak_valid <= w_strobe;
            if (w_strobe) begin
                r_peak_bin <= r_max_bin;
                r_peak_pow <= r_max_pow;
                r_energy   <= r_acc_eng;
            end
        end
    end

    assign busy       = (r_state == ACCUM) || (r_state == DRAIN);
    assign peak_valid = r_peak_valid;
    assign peak_bin   = r_peak_bin;
    assign peak_pow   = r_peak_pow;
    assign energy     = r_energy;

endmodule

// File: tb/tb_fft_peak_finder.sv
// Directed bench for fft_peak_finder: one instance with DC searched, one with DC skipped.
module tb_fft_peak_finder;

    logic               clk;
    logic               rst_n;
    logic               clr;
    logic               in_valid;
    logic signed [15:0] din_r;
    logic signed [15:0] din_i;

    logic               busy_a;
    logic               pv_a;
    logic [4:0]         bin_a;
    logic [31:0]        pow_a;
    logic [36:0]        eng_a;

    logic               busy_b;
    logic               pv_b;
    logic [4:0]         bin_b;
    logic [31:0]        pow_b;
    logic [36:0]        eng_b;

    logic signed [15:0] re_v [32];
    logic signed [15:0] im_v [32];

    int n_chk;
    int n_pass;
    int n_pv_a;
    int n_pv_b;
    int base_a;
    int base_b;
    int gap_at;

    fft_peak_finder #(
        .N_PT    (32),
        .DW      (16),
        .SKIP_DC (1'b0)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .in_valid   (in_valid),
        .din_r      (din_r),
        .din_i      (din_i),
        .busy       (busy_a),
        .peak_valid (pv_a),
        .peak_bin   (bin_a),
        .peak_pow   (pow_a),
        .energy     (eng_a)
    );

    fft_peak_finder #(
        .N_PT    (32),
        .DW      (16),
        .SKIP_DC (1'b1)
    ) u_dut_skip (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .in_valid   (in_valid),
        .din_r      (din_r),
        .din_i      (din_i),
        .busy       (busy_b),
        .peak_valid (pv_b),
        .peak_bin   (bin_b),
        .peak_pow   (pow_b),
        .energy     (eng_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pv_a) n_pv_a <= n_pv_a + 1;
        if (pv_b) n_pv_b <= n_pv_b + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_res(input string tag, input bit skip, input logic [63:0] e_bin,
                           input logic [63:0] e_pow, input logic [63:0] e_eng);
        if (skip) begin
            chk({tag, "_skip_bin"}, 64'(bin_b), e_bin);
            chk({tag, "_skip_pow"}, 64'(pow_b), e_pow);
            chk({tag, "_skip_eng"}, 64'(eng_b), e_eng);
        end else begin
            chk({tag, "_bin"}, 64'(bin_a), e_bin);
            chk({tag, "_pow"}, 64'(pow_a), e_pow);
            chk({tag, "_eng"}, 64'(eng_a), e_eng);
        end
    endtask

    task automatic clear_vec();
        for (int k = 0; k < 32; k++) begin
            re_v[k] = '0;
            im_v[k] = '0;
        end
    endtask

    // Called at a negedge; returns at the negedge following the edge that samples the last bin.
    task automatic send_frame(input int nbins, input int gap_pos, input int gap_len,
                              input logic tail_valid);
        for (int k = 0; k < nbins; k++) begin
            if (k == gap_pos) begin
                in_valid = 1'b0;
                repeat (gap_len) @(negedge clk);
            end
            in_valid = 1'b1;
            din_r    = re_v[k];
            din_i    = im_v[k];
            @(negedge clk);
        end
        in_valid = tail_valid;
    endtask

    // Strobe must appear after the 3rd rising edge following the last-bin edge, for one cycle.
    task automatic chk_latency(input string tag);
        chk({tag, "_busy_drain"}, 64'(busy_a), 64'd1);
        chk({tag, "_pv_t1"}, 64'({pv_a, pv_b}), 64'd0);
        @(negedge clk);
        chk({tag, "_pv_t2"}, 64'({pv_a, pv_b}), 64'd0);
        @(negedge clk);
        chk({tag, "_pv_t3"}, 64'({pv_a, pv_b}), 64'd0);
        @(negedge clk);
        chk({tag, "_pv_t4"}, 64'({pv_a, pv_b}), 64'd3);
        chk({tag, "_busy_done"}, 64'({busy_a, busy_b}), 64'd0);
        @(negedge clk);
        chk({tag, "_pv_t5"}, 64'({pv_a, pv_b}), 64'd0);
    endtask

    initial begin
        n_chk    = 0;
        n_pass   = 0;
        n_pv_a   = 0;
        n_pv_b   = 0;
        rst_n    = 1'b0;
        clr      = 1'b0;
        in_valid = 1'b0;
        din_r    = '0;
        din_i    = '0;
        clear_vec();
        repeat (3) @(negedge clk);

        chk("rst_outs_a", 64'({busy_a, pv_a}), 64'd0);
        chk_res("rst", 1'b0, 64'd0, 64'd0, 64'd0);
        chk_res("rst", 1'b1, 64'd0, 64'd0, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single tone at bin 5.
        clear_vec();
        re_v[5] = 16'sd1000;
        base_a  = n_pv_a;
        send_frame(32, -1, 0, 1'b0);
        chk_latency("tone");
        chk_res("tone", 1'b0, 64'd5, 64'd1000000, 64'd1000000);
        chk_res("tone", 1'b1, 64'd5, 64'd1000000, 64'd1000000);
        repeat (3) @(negedge clk);
        chk("tone_strobes", 64'(n_pv_a - base_a), 64'd1);
        chk_res("tone_hold", 1'b0, 64'd5, 64'd1000000, 64'd1000000);

        // Tie between bins 3 and 9: lowest index wins.
        clear_vec();
        re_v[3] = -16'sd300;
        im_v[3] = 16'sd400;
        re_v[9] = -16'sd300;
        im_v[9] = 16'sd400;
        send_frame(32, -1, 0, 1'b0);
        chk_latency("tie");
        chk_res("tie", 1'b0, 64'd3, 64'd250000, 64'd500000);
        chk_res("tie", 1'b1, 64'd3, 64'd250000, 64'd500000);
        repeat (2) @(negedge clk);

        // Full-scale negative on every bin: no wrap in power or energy.
        for (int k = 0; k < 32; k++) begin
            re_v[k] = -16'sd32768;
            im_v[k] = -16'sd32768;
        end
        send_frame(32, -1, 0, 1'b0);
        chk_latency("ext");
        chk_res("ext", 1'b0, 64'd0, 64'd2147483648, 64'd68719476736);
        chk_res("ext", 1'b1, 64'd1, 64'd2147483648, 64'd68719476736);
        repeat (2) @(negedge clk);

        // Mid-frame gap of 4 cycles, then sticky valid for 50 cycles after the frame.
        for (int k = 0; k < 32; k++) begin
            re_v[k] = 16'(k);
            im_v[k] = -16'(k);
        end
        gap_at = int'($urandom_range(30, 1));
        base_a = n_pv_a;
        base_b = n_pv_b;
        send_frame(32, gap_at, 4, 1'b1);
        chk_latency("gap");
        chk_res("gap", 1'b0, 64'd31, 64'd1922, 64'd20832);
        chk_res("gap", 1'b1, 64'd31, 64'd1922, 64'd20832);
        repeat (46) @(negedge clk);
        chk("sticky_strobes_a", 64'(n_pv_a - base_a), 64'd1);
        chk("sticky_strobes_b", 64'(n_pv_b - base_b), 64'd1);
        chk("sticky_busy", 64'({busy_a, busy_b}), 64'd0);

        // Second frame after exactly one low cycle; also the DC-skip case.
        in_valid = 1'b0;
        @(negedge clk);
        clear_vec();
        re_v[0] = 16'sd2000;
        re_v[7] = 16'sd10;
        im_v[7] = 16'sd10;
        send_frame(32, -1, 0, 1'b0);
        chk_latency("dc");
        chk_res("dc", 1'b0, 64'd0, 64'd4000000, 64'd4000200);
        chk_res("dc", 1'b1, 64'd7, 64'd200, 64'd4000200);
        repeat (2) @(negedge clk);

        // clr at bin 20: frame dropped, previous results kept.
        for (int k = 0; k < 32; k++) begin
            re_v[k] = 16'sd500;
            im_v[k] = 16'sd0;
        end
        base_a = n_pv_a;
        send_frame(20, -1, 0, 1'b1);
        din_r = re_v[20];
        clr   = 1'b1;
        @(negedge clk);
        clr      = 1'b0;
        in_valid = 1'b0;
        chk("clr_busy", 64'({busy_a, busy_b}), 64'd0);
        repeat (10) @(negedge clk);
        chk("clr_strobes", 64'(n_pv_a - base_a), 64'd0);
        chk_res("clr_keep", 1'b0, 64'd0, 64'd4000000, 64'd4000200);
        chk_res("clr_keep", 1'b1, 64'd7, 64'd200, 64'd4000200);

        // clr on the cycle that would strobe suppresses it.
        base_a = n_pv_a;
        send_frame(32, -1, 0, 1'b0);
        repeat (2) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_strobe_pv", 64'({pv_a, pv_b}), 64'd0);
        repeat (5) @(negedge clk);
        chk("clr_strobe_cnt", 64'(n_pv_a - base_a), 64'd0);
        chk_res("clr_strobe_keep", 1'b0, 64'd0, 64'd4000000, 64'd4000200);

        // Reset at bin 20: no strobe, results zeroed.
        base_a = n_pv_a;
        send_frame(20, -1, 0, 1'b1);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("rst_mid_strobes", 64'(n_pv_a - base_a), 64'd0);
        chk("rst_mid_busy", 64'({busy_a, busy_b}), 64'd0);
        chk_res("rst_mid", 1'b0, 64'd0, 64'd0, 64'd0);
        chk_res("rst_mid", 1'b1, 64'd0, 64'd0, 64'd0);

        // Next full frame after abort and reset.
        clear_vec();
        re_v[5] = 16'sd1000;
        send_frame(32, -1, 0, 1'b0);
        chk_latency("after");
        chk_res("after", 1'b0, 64'd5, 64'd1000000, 64'd1000000);
        chk_res("after", 1'b1, 64'd5, 64'd1000000, 64'd1000000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
